// File: rtl/missile_move_ctrl.sv
// missile_move_ctrl
//   Motion and lifetime controller for one tank missile. A fire request in
//   IDLE launches the missile from the centre of the owning tank. The missile
//   then moves SPEED pixels per frame in the latched direction. It stops on a
//   collision or at a screen edge, explodes for EXPLODE_FRAMES frames, and
//   then returns to IDLE.
//
//   Ports
//     clk, resetN        clock, asynchronous active-low reset
//     startOfFrame_i     one-cycle pulse per video frame
//     fire_i             launch request (level or pulse)
//     tankX_i, tankY_i   owning tank top-left corner, sampled at launch only
//     tankDir_i          tank direction: 00 up, 01 right, 10 down, 11 left
//     collision_i        missile hit something this cycle
//     topLeftX_o/Y_o     missile top-left corner
//     dir_o              latched launch direction
//     missileActive_o    high while flying (draw enable)
//     exploding_o        high during the explosion phase
//     hitPulse_o         one-cycle pulse when flight ends by collision
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | no missile, waiting for fire_i
//   FLY     | missile moving, one step per startOfFrame_i
//   EXPLODE | position held, counting EXPLODE_FRAMES frame pulses

module missile_move_ctrl #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int TANK_SIZE      = 32,
    parameter int MISSILE_SIZE   = 8,
    parameter int SPEED          = 4,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame_i,
    input  logic        fire_i,
    input  logic [10:0] tankX_i,
    input  logic [10:0] tankY_i,
    input  logic [1:0]  tankDir_i,
    input  logic        collision_i,
    output logic [10:0] topLeftX_o,
    output logic [10:0] topLeftY_o,
    output logic [1:0]  dir_o,
    output logic        missileActive_o,
    output logic        exploding_o,
    output logic        hitPulse_o
);

    localparam int CNT_W = (EXPLODE_FRAMES > 2) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic [1:0]  DIR_UP    = 2'b00;
    localparam logic [1:0]  DIR_RIGHT = 2'b01;
    localparam logic [1:0]  DIR_DOWN  = 2'b10;
    localparam logic [1:0]  DIR_LEFT  = 2'b11;

    localparam logic [10:0] LAUNCH_OFS = 11'((TANK_SIZE - MISSILE_SIZE) / 2);
    localparam logic [11:0] STEP       = 12'(SPEED);
    localparam logic [11:0] LIMIT_X    = 12'(SCREEN_W - MISSILE_SIZE);
    localparam logic [11:0] LIMIT_Y    = 12'(SCREEN_H - MISSILE_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPLODE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        EXPLODE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      x_q, x_d, y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic             active_q, active_d;
    logic             expl_q, expl_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Edge checks run in 12 bits so that x+SPEED cannot wrap past the limit.
    logic [11:0] x_ext, y_ext, x_inc, y_inc;
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_inc = x_ext + STEP;
    assign y_inc = y_ext + STEP;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= DIR_RIGHT;
            active_q <= 1'b0;
            expl_q   <= 1'b0;
            hit_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            active_q <= active_d;
            expl_q   <= expl_d;
            hit_q    <= hit_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        hit_d   = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fire_i) begin
                    state_d = FLY;
                    x_d     = tankX_i + LAUNCH_OFS;
                    y_d     = tankY_i + LAUNCH_OFS;
                    dir_d   = tankDir_i;
                end
            end

            FLY: begin
                cnt_d = '0;
                // Collision has priority over a same-cycle frame step.
                if (collision_i) begin
                    state_d = EXPLODE;
                    hit_d   = 1'b1;
                end else if (startOfFrame_i) begin
                    unique case (dir_q)
                        DIR_UP: begin
                            if (y_ext < STEP) begin
                                y_d     = '0;
                                state_d = EXPLODE;
                            end else begin
                                y_d = y_q - STEP[10:0];
                            end
                        end
                        DIR_RIGHT: begin
                            if (x_inc > LIMIT_X) begin
                                x_d     = LIMIT_X[10:0];
                                state_d = EXPLODE;
                            end else begin
                                x_d = x_inc[10:0];
                            end
                        end
                        DIR_DOWN: begin
                            if (y_inc > LIMIT_Y) begin
                                y_d     = LIMIT_Y[10:0];
                                state_d = EXPLODE;
                            end else begin
                                y_d = y_inc[10:0];
                            end
                        end
                        DIR_LEFT: begin
                            if (x_ext < STEP) begin
                                x_d     = '0;
                                state_d = EXPLODE;
                            end else begin
                                x_d = x_q - STEP[10:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end

            EXPLODE: begin
                if (startOfFrame_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Flags are registered from the next state so they line up with it.
        active_d = (state_d == FLY);
        expl_d   = (state_d == EXPLODE);
    end

    assign topLeftX_o      = x_q;
    assign topLeftY_o      = y_q;
    assign dir_o           = dir_q;
    assign missileActive_o = active_q;
    assign exploding_o     = expl_q;
    assign hitPulse_o      = hit_q;

endmodule

// File: tb/tb_missile_move_ctrl.sv
// tb_missile_move_ctrl
//   Directed scenarios followed by random stimulus. Every cycle the DUT
//   outputs are compared with a frame-level reference model that tracks the
//   missile as "idle / flying / exploding with N frames left".

module tb_missile_move_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame_i;
    logic        fire_i;
    logic [10:0] tankX_i, tankY_i;
    logic [1:0]  tankDir_i;
    logic        collision_i;
    logic [10:0] topLeftX_o, topLeftY_o;
    logic [1:0]  dir_o;
    logic        missileActive_o, exploding_o, hitPulse_o;

    int checks = 0;
    int errors = 0;

    // reference model
    bit m_fly, m_exp, m_hit;
    int m_x, m_y, m_dir, m_left;

    always #5 clk = ~clk;

    missile_move_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame_i  (startOfFrame_i),
        .fire_i          (fire_i),
        .tankX_i         (tankX_i),
        .tankY_i         (tankY_i),
        .tankDir_i       (tankDir_i),
        .collision_i     (collision_i),
        .topLeftX_o      (topLeftX_o),
        .topLeftY_o      (topLeftY_o),
        .dir_o           (dir_o),
        .missileActive_o (missileActive_o),
        .exploding_o     (exploding_o),
        .hitPulse_o      (hitPulse_o)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fly = 0; m_exp = 0; m_hit = 0;
        m_x = 0; m_y = 0; m_dir = 1; m_left = 0;
    endtask

    // One clock edge of the missile's life, in screen terms.
    task automatic model_step();
        m_hit = 0;
        if (!m_fly && !m_exp) begin
            if (fire_i) begin
                m_fly = 1;
                m_x   = (int'(tankX_i) + 12) % 2048;
                m_y   = (int'(tankY_i) + 12) % 2048;
                m_dir = int'(tankDir_i);
            end
        end else if (m_fly) begin
            if (collision_i) begin
                m_fly = 0; m_exp = 1; m_hit = 1; m_left = 8;
            end else if (startOfFrame_i) begin
                bit stop;
                stop = 0;
                case (m_dir)
                    0: if (m_y < 4) begin m_y = 0; stop = 1; end else m_y -= 4;
                    1: if (m_x + 4 > 632) begin m_x = 632; stop = 1; end else m_x += 4;
                    2: if (m_y + 4 > 472) begin m_y = 472; stop = 1; end else m_y += 4;
                    default: if (m_x < 4) begin m_x = 0; stop = 1; end else m_x -= 4;
                endcase
                if (stop) begin
                    m_fly = 0; m_exp = 1; m_left = 8;
                end
            end
        end else begin
            if (startOfFrame_i) begin
                m_left--;
                if (m_left == 0) m_exp = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".x"},      int'(topLeftX_o),      m_x);
        check_val({tag, ".y"},      int'(topLeftY_o),      m_y);
        check_val({tag, ".dir"},    int'(dir_o),           m_dir);
        check_val({tag, ".active"}, int'(missileActive_o), int'(m_fly));
        check_val({tag, ".expl"},   int'(exploding_o),     int'(m_exp));
        check_val({tag, ".hit"},    int'(hitPulse_o),      int'(m_hit));
    endtask

    // Called at a negedge: apply inputs, clock once, compare at next negedge.
    task automatic step(input bit sof, input bit fire, input bit coll, input string tag);
        startOfFrame_i = sof;
        fire_i         = fire;
        collision_i    = coll;
        @(posedge clk);
        if (resetN) model_step();
        else        model_reset();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, tag);
            step(0, 0, 0, tag);
        end
    endtask

    task automatic set_tank(input int x, input int y, input int d);
        tankX_i   = 11'(x);
        tankY_i   = 11'(y);
        tankDir_i = 2'(d);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame_i = 0; fire_i = 0; collision_i = 0;
        set_tank(0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        resetN = 1'b1;
        step(0, 0, 0, "idle");

        // basic launch and move right
        set_tank(100, 200, 1);
        step(0, 1, 0, "launch");
        check_val("launch_x_const", int'(topLeftX_o), 112);
        check_val("launch_y_const", int'(topLeftY_o), 212);
        check_val("launch_act_const", int'(missileActive_o), 1);
        frames(3, "move_right");
        check_val("x_after3_const", int'(topLeftX_o), 124);

        // collision with frame pulse, fire during fly and explode ignored
        step(0, 1, 0, "fire_in_fly");
        step(1, 0, 1, "coll_sof");
        check_val("coll_x_const", int'(topLeftX_o), 124);
        check_val("coll_hit_const", int'(hitPulse_o), 1);
        step(0, 1, 0, "fire_in_expl");
        check_val("hit_once_const", int'(hitPulse_o), 0);
        frames(7, "explode");
        check_val("expl_7_const", int'(exploding_o), 1);
        frames(1, "explode_end");
        check_val("expl_8_const", int'(exploding_o), 0);

        // up edge: 12 -> 8 -> 4 -> 0 -> stop
        set_tank(50, 0, 0);
        step(0, 1, 0, "launch_up");
        frames(3, "up");
        check_val("up_y0_const", int'(topLeftY_o), 0);
        check_val("up_still_fly", int'(missileActive_o), 1);
        frames(1, "up_edge");
        check_val("up_edge_expl", int'(exploding_o), 1);
        check_val("up_edge_hit", int'(hitPulse_o), 0);
        frames(8, "up_explode");

        // right edge clamp at 632
        set_tank(600, 100, 1);
        step(0, 1, 0, "launch_right");
        frames(5, "right");
        check_val("right_632", int'(topLeftX_o), 632);
        check_val("right_fly", int'(missileActive_o), 1);
        frames(1, "right_edge");
        check_val("right_edge_x", int'(topLeftX_o), 632);
        check_val("right_edge_expl", int'(exploding_o), 1);

        // async reset in explosion with counter at 5
        frames(5, "pre_reset");
        #2 resetN = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset");
        @(negedge clk);
        resetN = 1'b1;
        step(0, 0, 0, "post_reset");
        step(1, 0, 0, "post_reset");
        check_val("post_reset_idle", int'(missileActive_o), 0);
        set_tank(300, 300, 3);
        step(0, 1, 0, "relaunch");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_tank(int'($urandom_range(0, 640)), int'($urandom_range(0, 480)),
                         int'($urandom_range(0, 3)));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/missile_move_ctrl.md
Name: missile_move_ctrl

Overview:
- Motion and lifetime controller for one tank missile; drives the position/direction inputs of the missile square object and the explosion draw logic.
- Launches on a fire request from the owning tank, advances once per video frame in the launch direction, and stops on a collision or at a screen edge.
- Holds an explosion phase for a fixed number of frames, then returns to idle so the next shot can be fired.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- TANK_SIZE, 32, tank square side in pixels.
- MISSILE_SIZE, 8, missile square side in pixels.
- SPEED, 4, pixels moved per frame.
- EXPLODE_FRAMES, 8, number of frames the explosion phase lasts.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse, once per frame
- fire  in  1  launch request (level or pulse)
- tankX  in  11  owning tank top-left X
- tankY  in  11  owning tank top-left Y
- tankDir  in  2  tank direction: 00 up, 01 right, 10 down, 11 left
- collision  in  1  missile hit something this cycle
- topLeftX  out  11  missile top-left X
- topLeftY  out  11  missile top-left Y
- dir  out  2  latched launch direction, same encoding as tankDir
- missileActive  out  1  high in FLY (missile drawing enable)
- exploding  out  1  high in EXPLODE
- hitPulse  out  1  one-cycle pulse when FLY ends by collision

Behaviour:
- Reset state, applied asynchronously:
  - state IDLE
  - topLeftX = 0, topLeftY = 0
  - dir = 01
  - missileActive = 0, exploding = 0, hitPulse = 0
  - frame counter = 0
- All outputs are registered.
- States are IDLE, FLY and EXPLODE.
- IDLE:
  - On fire = 1, next cycle go to FLY.
  - Launch loads topLeftX = tankX + (TANK_SIZE-MISSILE_SIZE)/2 and topLeftY = tankY + (TANK_SIZE-MISSILE_SIZE)/2; with defaults this is +12.
  - Launch also loads dir = tankDir.
  - A startOfFrame in the launch cycle causes no move; the first move happens on the next startOfFrame.
- FLY:
  - missileActive = 1.
  - fire is ignored; one missile is in flight at a time.
  - On startOfFrame with collision = 0, move SPEED pixels in dir:
    - up: Y -= SPEED
    - right: X += SPEED
    - down: Y += SPEED
    - left: X -= SPEED
  - Edge checks use 12-bit unsigned arithmetic, so there is no wraparound:
    - up: if Y < SPEED, set Y = 0 and go to EXPLODE.
    - left: if X < SPEED, set X = 0 and go to EXPLODE.
    - right: if X + SPEED > SCREEN_W-MISSILE_SIZE, clamp X to that limit and go to EXPLODE.
    - down: if Y + SPEED > SCREEN_H-MISSILE_SIZE, clamp Y to that limit and go to EXPLODE.
  - Edge-stop does not assert hitPulse.
  - collision = 1 in any FLY cycle: next cycle go to EXPLODE, position frozen, hitPulse = 1 for exactly one cycle.
  - collision and startOfFrame in the same cycle: collision wins and no move is applied.
- EXPLODE:
  - exploding = 1, missileActive = 0; position and dir are held.
  - The counter is cleared on entry and incremented on each startOfFrame.
  - When the counter reaches EXPLODE_FRAMES-1 and a startOfFrame arrives, go to IDLE next cycle; EXPLODE therefore lasts exactly EXPLODE_FRAMES frame pulses.
  - fire and collision are ignored.
- IDLE outputs: missileActive = 0 and exploding = 0; position and dir keep their last values.
- fire held high continuously relaunches one cycle after EXPLODE returns to IDLE.
- tankX/tankY/tankDir are sampled only in the launch cycle.
- resetN low mid-flight or mid-explosion returns immediately to the reset state; there is no pending launch after reset release.

Test Plan:
- Reset, tankX=100, tankY=200, tankDir=01, pulse fire -> next cycle missileActive=1, topLeftX=112, topLeftY=212, dir=01; after 3 startOfFrame pulses topLeftX=124.
- Launch from tankY=0, tankDir=00 (topLeftY=12) -> after 3 frames Y=0 and still FLY; at the 4th frame EXPLODE with Y=0 and hitPulse=0.
- In FLY, assert collision together with startOfFrame -> position unchanged, hitPulse high one cycle, exploding=1; exactly 8 startOfFrame pulses later the block is back in IDLE.
- Pulse fire during FLY and during EXPLODE -> no relaunch, position unaffected; fire in IDLE -> launch.
- tankX=600, tankDir=01 (X=612, limit 632) -> frames give 616, 620, 624, 628, 632; the next frame sees 632+4>632 and goes to EXPLODE with X=632.
- Assert resetN low during EXPLODE with counter=5 -> outputs at reset values asynchronously; after release, IDLE waits for fire.
